// File: rtl/sdram_cmd_fsm.sv
// sdram_cmd_fsm: single-word SDRAM access sequencer with power-up init and auto-refresh
module sdram_cmd_fsm #(
  parameter int          T_RCD        = 2,
  parameter int          CAS_LAT      = 2,
  parameter int          T_WR         = 2,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          REF_INTERVAL = 780,
  parameter int          INIT_WAIT    = 100,
  parameter logic [11:0] MODE_REG     = 12'h020
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        ENABLE,
  input  logic        W_EN,
  input  logic        R_EN,
  input  logic [1:0]  MEM_BA,
  input  logic [11:0] MEM_ADDR,
  input  logic [31:0] HWDATA,
  output logic        BUSYn,
  output logic [31:0] HRDATA_R,
  output logic        SD_CKE,
  output logic        SD_CS_N,
  output logic        SD_RAS_N,
  output logic        SD_CAS_N,
  output logic        SD_WE_N,
  output logic [1:0]  SD_BA,
  output logic [11:0] SD_A,
  output logic [31:0] SD_DQ_OUT,
  output logic        SD_DQ_OE,
  input  logic [31:0] SD_DQ_IN
);
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  // each state names the command issued once the gap counter has drained
  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_REF1 = 4'd1;
  localparam logic [3:0] S_REF2 = 4'd2;
  localparam logic [3:0] S_MRS  = 4'd3;
  localparam logic [3:0] S_RDY  = 4'd4;
  localparam logic [3:0] S_IDLE = 4'd5;
  localparam logic [3:0] S_ACT  = 4'd6;
  localparam logic [3:0] S_RW   = 4'd7;
  localparam logic [3:0] S_PRE  = 4'd8;
  localparam logic [15:0] GAP_INIT = 16'(INIT_WAIT);
  localparam logic [15:0] GAP_RCD  = 16'(T_RCD - 1);
  localparam logic [15:0] GAP_WR   = 16'(T_WR);
  localparam logic [15:0] GAP_CL   = 16'(CAS_LAT);
  localparam logic [15:0] GAP_RP   = 16'(T_RP - 1);
  localparam logic [15:0] GAP_RFC  = 16'(T_RFC - 1);
  localparam logic [15:0] GAP_MRS  = 16'd2;
  localparam logic [15:0] REF_LOAD = 16'(REF_INTERVAL);
  localparam logic [11:0] A_PALL   = 12'h400;
  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [11:0] a_q, a_d;
  logic [31:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic        busy_n_q, busy_n_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  bank_q, bank_d;
  logic [11:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        cap_q, cap_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d;
  logic        done_q, done_d;
  logic        cke_q;
  logic        ref_clr;
  logic        req;
  assign req = ENABLE && (W_EN || R_EN);
  assign {SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N} = cmd_q;
  assign SD_CKE    = cke_q;
  assign SD_BA     = ba_q;
  assign SD_A      = a_q;
  assign SD_DQ_OUT = dq_q;
  assign SD_DQ_OE  = oe_q;
  assign BUSYn     = busy_n_q;
  assign HRDATA_R  = rdata_q;
  // command sequencer: NOPs while the gap counter drains, then the state's command
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = CMD_NOP;
    ba_d     = ba_q;
    a_d      = a_q;
    dq_d     = dq_q;
    oe_d     = 1'b0;
    busy_n_d = busy_n_q;
    rdata_d  = rdata_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    cap_d    = 1'b0;
    wdata_d  = (cap_q && wr_q) ? HWDATA : wdata_q;
    done_d   = done_q;
    ref_clr  = 1'b0;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          cmd_d   = CMD_PRE;
          a_d     = A_PALL;
          cnt_d   = GAP_RP;
          state_d = S_REF1;
        end
        S_REF1: begin
          cmd_d   = CMD_REF;
          cnt_d   = GAP_RFC;
          state_d = S_REF2;
        end
        S_REF2: begin
          cmd_d   = CMD_REF;
          cnt_d   = GAP_RFC;
          state_d = S_MRS;
        end
        S_MRS: begin
          cmd_d   = CMD_MRS;
          a_d     = MODE_REG;
          ba_d    = 2'd0;
          cnt_d   = GAP_MRS;
          state_d = S_RDY;
        end
        S_RDY: begin
          busy_n_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        S_IDLE: begin
          if (req) begin
            bank_d   = MEM_BA;
            addr_d   = MEM_ADDR;
            wr_d     = W_EN;
            cap_d    = 1'b1;
            busy_n_d = 1'b0;
            cmd_d    = ref_pend_q ? CMD_REF : CMD_ACT;
            ref_clr  = ref_pend_q;
            ba_d     = ref_pend_q ? ba_q : MEM_BA;
            a_d      = ref_pend_q ? a_q : {4'b0, MEM_ADDR[11:4]};
            cnt_d    = ref_pend_q ? GAP_RFC : GAP_RCD;
            state_d  = ref_pend_q ? S_ACT : S_RW;
          end else if (ref_pend_q) begin
            busy_n_d = 1'b0;
            cmd_d    = CMD_REF;
            ref_clr  = 1'b1;
            cnt_d    = GAP_RFC;
            state_d  = S_RDY;
          end
        end
        S_ACT: begin
          cmd_d   = CMD_ACT;
          ba_d    = bank_q;
          a_d     = {4'b0, addr_q[11:4]};
          cnt_d   = GAP_RCD;
          state_d = S_RW;
        end
        S_RW: begin
          cmd_d   = wr_q ? CMD_WR : CMD_RD;
          ba_d    = bank_q;
          a_d     = {8'b0, addr_q[3:0]};
          oe_d    = wr_q;
          dq_d    = wr_q ? wdata_d : dq_q;
          cnt_d   = wr_q ? GAP_WR : GAP_CL;
          state_d = S_PRE;
        end
        S_PRE: begin
          cmd_d   = CMD_PRE;
          a_d     = A_PALL;
          rdata_d = wr_q ? rdata_q : SD_DQ_IN;
          cnt_d   = GAP_RP;
          state_d = S_RDY;
        end
        default: state_d = S_INIT;
      endcase
    end
  end
  // refresh timer runs only after init; a pending request saturates until serviced
  always_comb begin
    ref_cnt_d  = !done_q ? ref_cnt_q : (ref_cnt_q == '0 ? REF_LOAD : ref_cnt_q - 1'b1);
    ref_pend_d = (done_q && ref_cnt_q == '0) || (ref_pend_q && !ref_clr);
  end
  // state and registered SDRAM/bus outputs
  always_ff @(posedge HCLK) begin
    cke_q <= 1'b1;
    if (HRESET) begin
      state_q    <= S_INIT;
      cnt_q      <= GAP_INIT;
      cmd_q      <= CMD_NOP;
      ba_q       <= '0;
      a_q        <= '0;
      dq_q       <= '0;
      oe_q       <= 1'b0;
      busy_n_q   <= 1'b0;
      rdata_q    <= '0;
      bank_q     <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      cap_q      <= 1'b0;
      wdata_q    <= '0;
      ref_cnt_q  <= REF_LOAD;
      ref_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      dq_q       <= dq_d;
      oe_q       <= oe_d;
      busy_n_q   <= busy_n_d;
      rdata_q    <= rdata_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      cap_q      <= cap_d;
      wdata_q    <= wdata_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_sdram_cmd_fsm.sv
// tb_sdram_cmd_fsm: directed bench for the SDRAM command sequencer
module tb_sdram_cmd_fsm;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        W_EN = 1'b0;
  logic        R_EN = 1'b0;
  logic [1:0]  MEM_BA = 2'd0;
  logic [11:0] MEM_ADDR = 12'd0;
  logic [31:0] HWDATA = 32'd0;
  logic        BUSYn;
  logic [31:0] HRDATA_R;
  logic        SD_CKE, SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N;
  logic [1:0]  SD_BA;
  logic [11:0] SD_A;
  logic [31:0] SD_DQ_OUT;
  logic        SD_DQ_OE;
  logic [31:0] SD_DQ_IN;
  logic [31:0] rd_word = 32'd0;
  logic        rd_p1 = 1'b0;
  logic        rd_p2 = 1'b0;
  logic [3:0]  cmd;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  sdram_cmd_fsm dut (
    .HCLK(HCLK), .HRESET(HRESET), .ENABLE(ENABLE), .W_EN(W_EN), .R_EN(R_EN),
    .MEM_BA(MEM_BA), .MEM_ADDR(MEM_ADDR), .HWDATA(HWDATA), .BUSYn(BUSYn),
    .HRDATA_R(HRDATA_R), .SD_CKE(SD_CKE), .SD_CS_N(SD_CS_N), .SD_RAS_N(SD_RAS_N),
    .SD_CAS_N(SD_CAS_N), .SD_WE_N(SD_WE_N), .SD_BA(SD_BA), .SD_A(SD_A),
    .SD_DQ_OUT(SD_DQ_OUT), .SD_DQ_OE(SD_DQ_OE), .SD_DQ_IN(SD_DQ_IN)
  );
  assign cmd = {SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N};
  always #5 HCLK = ~HCLK;
  // device model: read data appears two cycles after a READ command, junk otherwise
  always @(posedge HCLK) begin
    rd_p1 <= (cmd == RD);
    rd_p2 <= rd_p1;
  end
  assign SD_DQ_IN = rd_p2 ? rd_word : 32'hBAD0BAD0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask
  function automatic logic [3:0] init_cmd(input int k);
    if (k == 101) return PRE;
    if (k == 103 || k == 110) return REF;
    if (k == 117) return MRS;
    return NOP;
  endfunction
  task automatic run_init();
    for (int k = 1; k <= 119; k++) begin
      tick();
      chk("init_cmd", 32'(cmd), 32'(init_cmd(k)));
      if (k == 101) chk("init_pre_a10", 32'(SD_A[10]), 32'd1);
      if (k == 117) chk("init_mrs_a", 32'(SD_A), 32'h020);
      if (k == 117) chk("init_mrs_ba", 32'(SD_BA), 32'd0);
      if (k == 119) chk("init_busy_low", 32'(BUSYn), 32'd0);
    end
    tick();
    chk("init_busy_rise", 32'(BUSYn), 32'd1);
    chk("init_idle_cmd", 32'(cmd), 32'(NOP));
  endtask
  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_cmd", 32'(cmd), 32'(NOP));
    chk("rst_busy", 32'(BUSYn), 32'd0);
    chk("rst_cke", 32'(SD_CKE), 32'd1);
    chk("rst_a", 32'(SD_A), 32'd0);
    chk("rst_ba", 32'(SD_BA), 32'd0);
    chk("rst_oe", 32'(SD_DQ_OE), 32'd0);
    chk("rst_dq", SD_DQ_OUT, 32'd0);
    chk("rst_hrdata", HRDATA_R, 32'd0);
    HRESET = 1'b0;
    cyc = 0;
    run_init();
    // write BA=2 ADDR=A5C
    ENABLE = 1; W_EN = 1; MEM_BA = 2'd2; MEM_ADDR = 12'hA5C; HWDATA = 32'd0;
    tick();
    ENABLE = 0; W_EN = 0; HWDATA = 32'hDEADBEEF;
    chk("wr_c1_cmd", 32'(cmd), 32'(ACT));
    chk("wr_c1_ba", 32'(SD_BA), 32'd2);
    chk("wr_c1_a", 32'(SD_A), 32'h0A5);
    chk("wr_c1_busy", 32'(BUSYn), 32'd0);
    tick();
    chk("wr_c2_cmd", 32'(cmd), 32'(NOP));
    HWDATA = 32'h5555AAAA;
    tick();
    chk("wr_c3_cmd", 32'(cmd), 32'(WR));
    chk("wr_c3_a", 32'(SD_A), 32'h00C);
    chk("wr_c3_ba", 32'(SD_BA), 32'd2);
    chk("wr_c3_oe", 32'(SD_DQ_OE), 32'd1);
    chk("wr_c3_dq", SD_DQ_OUT, 32'hDEADBEEF);
    tick();
    chk("wr_c4_oe", 32'(SD_DQ_OE), 32'd0);
    chk("wr_c4_cmd", 32'(cmd), 32'(NOP));
    tick();
    chk("wr_c5_cmd", 32'(cmd), 32'(NOP));
    tick();
    chk("wr_c6_cmd", 32'(cmd), 32'(PRE));
    chk("wr_c6_a10", 32'(SD_A[10]), 32'd1);
    tick();
    chk("wr_c7_busy", 32'(BUSYn), 32'd0);
    tick();
    chk("wr_c8_busy", 32'(BUSYn), 32'd1);
    chk("wr_c8_hrdata", HRDATA_R, 32'd0);
    // read BA=1 ADDR=013
    ENABLE = 1; R_EN = 1; MEM_BA = 2'd1; MEM_ADDR = 12'h013; rd_word = 32'h12345678;
    tick();
    ENABLE = 0; R_EN = 0;
    chk("rd_c1_cmd", 32'(cmd), 32'(ACT));
    chk("rd_c1_ba", 32'(SD_BA), 32'd1);
    chk("rd_c1_a", 32'(SD_A), 32'h001);
    repeat (2) tick();
    chk("rd_c3_cmd", 32'(cmd), 32'(RD));
    chk("rd_c3_a", 32'(SD_A), 32'h003);
    chk("rd_c3_oe", 32'(SD_DQ_OE), 32'd0);
    repeat (2) tick();
    chk("rd_c5_hrdata_old", HRDATA_R, 32'd0);
    tick();
    chk("rd_c6_cmd", 32'(cmd), 32'(PRE));
    chk("rd_c6_hrdata", HRDATA_R, 32'h12345678);
    tick();
    chk("rd_c7_busy", 32'(BUSYn), 32'd0);
    tick();
    chk("rd_c8_busy", 32'(BUSYn), 32'd1);
    chk("rd_c8_hrdata", HRDATA_R, 32'h12345678);
    // ENABLE without W_EN/R_EN is ignored
    ENABLE = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_only_cmd", 32'(cmd), 32'(NOP));
      chk("en_only_busy", 32'(BUSYn), 32'd1);
    end
    // both W_EN and R_EN: write wins
    W_EN = 1; R_EN = 1; MEM_BA = 2'd0; MEM_ADDR = 12'h7F1;
    tick();
    ENABLE = 0; W_EN = 0; R_EN = 0; HWDATA = 32'h0BADF00D;
    chk("both_c1_a", 32'(SD_A), 32'h07F);
    repeat (2) tick();
    chk("both_c3_cmd", 32'(cmd), 32'(WR));
    chk("both_c3_dq", SD_DQ_OUT, 32'h0BADF00D);
    repeat (5) tick();
    chk("both_c8_busy", 32'(BUSYn), 32'd1);
    chk("both_c8_hrdata", HRDATA_R, 32'h12345678);
    // refresh expires at edge 901; request sampled at edge 902 together with it
    while (cyc < 901) tick();
    chk("pre_ref_busy", 32'(BUSYn), 32'd1);
    ENABLE = 1; R_EN = 1; MEM_BA = 2'd3; MEM_ADDR = 12'hFFF; rd_word = 32'hCAFEF00D;
    tick();
    ENABLE = 0; R_EN = 0;
    chk("rr_c1_cmd", 32'(cmd), 32'(REF));
    chk("rr_c1_busy", 32'(BUSYn), 32'd0);
    repeat (6) tick();
    chk("rr_c7_cmd", 32'(cmd), 32'(NOP));
    chk("rr_c7_busy", 32'(BUSYn), 32'd0);
    tick();
    chk("rr_c8_cmd", 32'(cmd), 32'(ACT));
    chk("rr_c8_ba", 32'(SD_BA), 32'd3);
    chk("rr_c8_a", 32'(SD_A), 32'h0FF);
    repeat (2) tick();
    chk("rr_c10_cmd", 32'(cmd), 32'(RD));
    chk("rr_c10_a", 32'(SD_A), 32'h00F);
    repeat (5) tick();
    chk("rr_c15_busy", 32'(BUSYn), 32'd1);
    chk("rr_c15_hrdata", HRDATA_R, 32'hCAFEF00D);
    // next expiry at edge 1682, serviced alone in idle at edge 1683
    while (cyc < 1682) tick();
    chk("iref_pre_cmd", 32'(cmd), 32'(NOP));
    chk("iref_pre_busy", 32'(BUSYn), 32'd1);
    tick();
    chk("iref_cmd", 32'(cmd), 32'(REF));
    chk("iref_busy", 32'(BUSYn), 32'd0);
    repeat (6) tick();
    chk("iref_last_busy", 32'(BUSYn), 32'd0);
    tick();
    chk("iref_done_busy", 32'(BUSYn), 32'd1);
    chk("iref_done_cmd", 32'(cmd), 32'(NOP));
    // reset during c4 of a read
    ENABLE = 1; R_EN = 1; MEM_BA = 2'd0; MEM_ADDR = 12'h123; rd_word = 32'h99999999;
    tick();
    ENABLE = 0; R_EN = 0;
    repeat (2) tick();
    chk("rst_rd_c3_cmd", 32'(cmd), 32'(RD));
    tick();
    HRESET = 1;
    tick();
    chk("mid_rst_cmd", 32'(cmd), 32'(NOP));
    chk("mid_rst_busy", 32'(BUSYn), 32'd0);
    chk("mid_rst_oe", 32'(SD_DQ_OE), 32'd0);
    chk("mid_rst_hrdata", HRDATA_R, 32'd0);
    HRESET = 0;
    cyc = 0;
    run_init();
    chk("reinit_hrdata", HRDATA_R, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_fsm.md
Name: sdram_cmd_fsm

Overview:
- Downstream consumer of the AHB-Lite slave front end. It takes that stage's ENABLE, W_EN, R_EN, MEM_BA and MEM_ADDR, and returns BUSYn and HRDATA_R.
- Sequences single-word SDRAM accesses: ACTIVATE, then READ or WRITE, then PRECHARGE.
- Also performs the power-up init sequence and periodic auto-refresh, and stalls the bus via BUSYn.
- Targets a x32 single-data-rate SDRAM with a 12-bit address bus and 4 banks.

Parameters:
- T_RCD, 2, ACTIVATE to READ/WRITE spacing in cycles (>=1)
- CAS_LAT, 2, read CAS latency in cycles (2 or 3)
- T_WR, 2, cycles from WRITE to PRECHARGE (>=1)
- T_RP, 2, PRECHARGE to next command in cycles (>=1)
- T_RFC, 7, REFRESH to next command in cycles (>=1)
- REF_INTERVAL, 780, cycles between refresh requests
- INIT_WAIT, 100, power-up NOP cycles before init
- MODE_REG, 12'h020, mode word loaded by MRS (CL2, burst length 1)

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- ENABLE  in  1  request qualifier from the AHB stage
- W_EN  in  1  write request
- R_EN  in  1  read request
- MEM_BA  in  2  bank address
- MEM_ADDR  in  12  word address
- HWDATA  in  32  AHB write data (data phase)
- BUSYn  out  1  1 = idle and ready to accept; drives HREADYOUT
- HRDATA_R  out  32  last read data, registered
- SD_CKE  out  1  clock enable
- SD_CS_N  out  1  chip select
- SD_RAS_N  out  1  row address strobe
- SD_CAS_N  out  1  column address strobe
- SD_WE_N  out  1  write enable
- SD_BA  out  2  bank address
- SD_A  out  12  row/column/mode address
- SD_DQ_OUT  out  32  write data
- SD_DQ_OE  out  1  DQ output enable
- SD_DQ_IN  in  32  read data

Behaviour:
- Clock and reset: one clock, HCLK. Reset is HRESET, synchronous and active-high. All outputs are registered.
- Command encoding on {CS_N,RAS_N,CAS_N,WE_N}: NOP=0111, ACT=0011, READ=0101, WRITE=0100, PRE=0010 (SD_A[10]=1, all banks), REF=0001, MRS=0000.
- Reset values: state INIT_WAIT, command NOP, SD_CKE=1, SD_A=0, SD_BA=0, SD_DQ_OUT=0, SD_DQ_OE=0, BUSYn=0, HRDATA_R=0, refresh counter=REF_INTERVAL, pending flags clear.
- Reset asserted mid-operation aborts the access and restarts init. No PRE is issued.
- Init sequence:
  - INIT_WAIT NOPs.
  - PRE all, then T_RP-1 NOPs.
  - REF, then T_RFC-1 NOPs; repeat once (two refreshes total).
  - MRS with SD_A=MODE_REG and SD_BA=0, then 2 NOPs.
  - Enter IDLE with BUSYn=1.
- Accept rule: in IDLE with BUSYn=1, ENABLE&(W_EN|R_EN) is latched on the clock edge.
  - Latched fields: bank, addr, and write flag (W_EN wins if both are set).
  - BUSYn goes 0 on that same edge.
- Cycle numbering: c1 is the first cycle after the accept edge.
- c1 (ACT): SD_BA=bank, SD_A={4'b0, addr[11:4]}. On writes, HWDATA is captured at the end of c1.
- ACT is followed by T_RCD-1 NOPs.
- WRITE: SD_A={8'b0, addr[3:0]} (A10=0), SD_DQ_OUT=captured data, SD_DQ_OE=1 for that cycle only. Then T_WR NOPs.
- READ: same address as WRITE, SD_DQ_OE=0. Then CAS_LAT NOPs. HRDATA_R<=SD_DQ_IN on the last of those NOP cycles (CAS_LAT cycles after the READ cycle).
- Completion: PRE all, then T_RP-1 NOPs, then IDLE with BUSYn=1.
- Default-parameter latency: BUSYn is low for c1..c7 for both read and write. BUSYn=1 and HRDATA_R is valid at c8.
- HRDATA_R holds its value until the next read capture. Writes leave it unchanged.
- Refresh counter:
  - Decrements every cycle after init.
  - At 0, sets ref_pending and reloads REF_INTERVAL.
  - If already pending at the next expiry, stays pending (saturates).
- Refresh servicing:
  - In IDLE with ref_pending and no latched request: BUSYn=0, issue REF, then T_RFC-1 NOPs, return to IDLE, clear pending.
  - ref_pending and a request in the same IDLE cycle: the request is latched (the address phase completes). REF and T_RFC-1 NOPs run first, then the ACT sequence, with no return to IDLE between.
- Requests arriving while BUSYn=0 are ignored; the AHB stage holds them via HREADYOUT.
- ENABLE with neither W_EN nor R_EN is ignored.

Test Plan:
- Reset, then run until BUSYn=1 -> commands in order: 100 NOPs, PRE (A10=1), 1 NOP, REF, 6 NOPs, REF, 6 NOPs, MRS with SD_A=12'h020, 2 NOPs. BUSYn rises 1+100+2+7+7+1+2 cycles after reset release.
- Write BA=2, ADDR=12'hA5C, HWDATA=32'hDEADBEEF -> c1 ACT with SD_BA=2, SD_A=12'h0A5. c3 WRITE with SD_A=12'h00C, DQ_OE=1, DQ_OUT=DEADBEEF. c6 PRE. BUSYn=1 at c8.
- Read BA=1, ADDR=12'h013, device model drives 32'h12345678 two cycles after READ -> READ at c3. HRDATA_R=12345678 and BUSYn=1 at c8.
- Force refresh expiry in IDLE together with a read request -> REF issued at c1, ACT at c1+T_RFC. Read data is still correct.
- Assert HRESET at c4 of a read -> next cycle: command NOP, BUSYn=0, DQ_OE=0, HRDATA_R=0. Full init sequence repeats.
- ENABLE=1 with W_EN=R_EN=0 in IDLE -> no ACT issued, BUSYn stays 1.
